// File: rtl/bp_stream_byte_packer.sv
// Packs a host byte stream into stream_data_width_p-bit little-endian words behind a small FIFO.
// Optional idle flush of partial words: define BP_STREAM_PACKER_FLUSH_EN.
module bp_stream_byte_packer #(
    parameter int in_width_p          = 8,
    parameter int stream_data_width_p = 32,
    parameter int fifo_els_p          = 4,
    parameter int flush_cycles_p      = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           byte_v_i,
    input  logic [in_width_p-1:0]          byte_data_i,
    output logic                           byte_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_ready_i,
    output logic [31:0]                    word_count_o
);

    localparam int lanes_lp = stream_data_width_p / in_width_p;
    localparam int lane_w   = (lanes_lp > 1) ? $clog2(lanes_lp) : 1;
    localparam int ptr_w    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w    = $clog2(fifo_els_p + 1);

    if ((stream_data_width_p % in_width_p) != 0 || lanes_lp < 2 || fifo_els_p < 2
        || flush_cycles_p < 1) begin : g_param_check
        $error("bp_stream_byte_packer: illegal parameter combination");
    end

    // Both ports use valid/ready: a transfer happens on the rising clk_i edge where valid and
    // ready are both high; a valid word and its data hold steady until that transfer.

    logic [lane_w-1:0]                         lane_cnt;
    logic [lanes_lp-1:0][in_width_p-1:0]       held;
    logic [lanes_lp-1:0][in_width_p-1:0]       assembled;
    logic [stream_data_width_p-1:0]            mem [fifo_els_p];
    logic [ptr_w-1:0]                          wr_ptr;
    logic [ptr_w-1:0]                          rd_ptr;
    logic [cnt_w-1:0]                          fifo_cnt;
    logic                                      fifo_full;
    logic                                      byte_hs;
    logic                                      last_lane;
    logic                                      word_done;
    logic                                      flush_fire;
    logic                                      enq;
    logic                                      deq;
    logic [stream_data_width_p-1:0]            enq_data;

    assign fifo_full    = (fifo_cnt == cnt_w'(fifo_els_p));
    // No bypass: a full FIFO stalls input even if the head leaves this cycle.
    assign byte_ready_o = ~fifo_full & ~clear_i & ~reset_i;
    assign byte_hs      = byte_v_i & byte_ready_o;
    assign last_lane    = (lane_cnt == lane_w'(lanes_lp - 1));
    assign word_done    = byte_hs & last_lane;

    always_comb begin
        assembled           = held;
        assembled[lane_cnt] = byte_data_i;
    end

`ifdef BP_STREAM_PACKER_FLUSH_EN
    localparam int idle_w = $clog2(flush_cycles_p + 1);
    logic [idle_w-1:0] idle_cnt;

    // The idle counter saturates at flush_cycles_p so a blocked flush stays pending.
    assign flush_fire = (idle_cnt == idle_w'(flush_cycles_p)) & (lane_cnt != '0)
                        & ~fifo_full & ~clear_i & ~byte_hs;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idle_cnt <= '0;
        end else if (clear_i || byte_hs || flush_fire) begin
            idle_cnt <= '0;
        end else if (lane_cnt != '0 && idle_cnt != idle_w'(flush_cycles_p)) begin
            idle_cnt <= idle_cnt + idle_w'(1);
        end
    end
`else
    assign flush_fire = 1'b0;
`endif

    assign enq      = word_done | flush_fire;
    assign enq_data = word_done ? assembled : held;
    assign deq      = stream_v_o & stream_ready_i;

    // Held lanes return to zero after every word so a flushed partial word has zero upper lanes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lane_cnt <= '0;
            held     <= '0;
        end else if (clear_i) begin
            lane_cnt <= '0;
            held     <= '0;
        end else if (byte_hs) begin
            if (last_lane) begin
                lane_cnt <= '0;
                held     <= '0;
            end else begin
                lane_cnt       <= lane_cnt + lane_w'(1);
                held[lane_cnt] <= byte_data_i;
            end
        end else if (flush_fire) begin
            lane_cnt <= '0;
            held     <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= (wr_ptr == ptr_w'(fifo_els_p - 1)) ? '0 : wr_ptr + ptr_w'(1);
            end
            if (deq) begin
                rd_ptr <= (rd_ptr == ptr_w'(fifo_els_p - 1)) ? '0 : rd_ptr + ptr_w'(1);
            end
            case ({enq, deq})
                2'b10:   fifo_cnt <= fifo_cnt + cnt_w'(1);
                2'b01:   fifo_cnt <= fifo_cnt - cnt_w'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign stream_v_o    = (fifo_cnt != '0);
    assign stream_data_o = stream_v_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_count_o <= '0;
        end else if (deq) begin
            word_count_o <= word_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
// Directed bench for bp_stream_byte_packer; flush scenario runs when BP_STREAM_PACKER_FLUSH_EN is defined.
module tb_bp_stream_byte_packer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         clear_i;
    logic         byte_v_i;
    logic [7:0]   byte_data_i;
    logic         byte_ready_o;
    logic         stream_v_o;
    logic [W-1:0] stream_data_o;
    logic         stream_ready_i;
    logic [31:0]  word_count_o;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  exp_wc;

    bp_stream_byte_packer dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .byte_v_i       (byte_v_i),
        .byte_data_i    (byte_data_i),
        .byte_ready_o   (byte_ready_o),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_ready_i (stream_ready_i),
        .word_count_o   (word_count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_v_i    = 1'b1;
        byte_data_i = b;
        step();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; clear_i = 1'b0; byte_v_i = 1'b0; byte_data_i = '0; stream_ready_i = 1'b0;
        exp_wc = '0;
        #2;
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL rst_v: got %b want 0", stream_v_o); end
        checks++; if (stream_data_o !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", stream_data_o); end
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", byte_ready_o); end
        checks++; if (word_count_o !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", word_count_o); end
        step(); step();
        reset_i = 1'b0;
        #1;
        checks++; if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", byte_ready_o); end
    endtask

    task automatic test_single_word();
        stream_ready_i = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        byte_v_i = 1'b0;
        checks++; if (stream_v_o !== 1'b1) begin errors++; $display("FAIL t1_v: got %b want 1", stream_v_o); end
        checks++; if (stream_data_o !== 32'h44332211) begin errors++; $display("FAIL t1_data: got %h want 44332211", stream_data_o); end
        step();
        exp_wc++;
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL t1_count: got %0d want %0d", word_count_o, exp_wc); end
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL t1_v_after: got %b want 0", stream_v_o); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w;
        stream_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            byte_v_i = 1'b1;
            byte_data_i = 8'(i);
            #1;
            checks++; if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b want 1", i, byte_ready_o); end
            step();
        end
        for (int w_i = 0; w_i < 4; w_i++) begin
            exp_q.push_back({8'(4*w_i+3), 8'(4*w_i+2), 8'(4*w_i+1), 8'(4*w_i)});
        end
        byte_data_i = 8'hEE;
        #1;
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", byte_ready_o); end
        step();
        byte_v_i = 1'b0;
        checks++; if (stream_data_o !== 32'h03020100) begin errors++; $display("FAIL bp_stall_data: got %h want 03020100", stream_data_o); end
        stream_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = exp_q.pop_front();
            checks++; if (stream_v_o !== 1'b1) begin errors++; $display("FAIL bp_v_%0d: got %b want 1", k, stream_v_o); end
            checks++; if (stream_data_o !== w) begin errors++; $display("FAIL bp_data_%0d: got %h want %h", k, stream_data_o, w); end
            step();
            exp_wc++;
        end
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL bp_count: got %0d want %0d", word_count_o, exp_wc); end
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", stream_v_o); end
        checks++; if (byte_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_end: got %b want 1", byte_ready_o); end
    endtask

    task automatic test_clear();
        stream_ready_i = 1'b1;
        send_byte(8'hAA); send_byte(8'hBB);
        byte_v_i = 1'b1; byte_data_i = 8'hCC; clear_i = 1'b1;
        #1;
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b want 0", byte_ready_o); end
        step();
        clear_i = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        byte_v_i = 1'b0;
        checks++; if (stream_data_o !== 32'h04030201) begin errors++; $display("FAIL clr_data: got %h want 04030201", stream_data_o); end
        step();
        exp_wc++;
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL clr_extra: got %b want 0", stream_v_o); end
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL clr_count: got %0d want %0d", word_count_o, exp_wc); end
    endtask

    task automatic test_async_reset();
        stream_ready_i = 1'b0;
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2);
        byte_v_i = 1'b0;
        checks++; if (stream_v_o !== 1'b1) begin errors++; $display("FAIL ar_queued: got %b want 1", stream_v_o); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL ar_v: got %b want 0", stream_v_o); end
        checks++; if (stream_data_o !== '0) begin errors++; $display("FAIL ar_data: got %h want 0", stream_data_o); end
        checks++; if (word_count_o !== 32'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", word_count_o); end
        checks++; if (byte_ready_o !== 1'b0) begin errors++; $display("FAIL ar_ready: got %b want 0", byte_ready_o); end
        step();
        reset_i = 1'b0;
        exp_wc = '0;
        stream_ready_i = 1'b1;
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        byte_v_i = 1'b0;
        checks++; if (stream_data_o !== 32'h88776655) begin errors++; $display("FAIL ar_fresh: got %h want 88776655", stream_data_o); end
        step();
        exp_wc++;
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL ar_count_after: got %0d want %0d", word_count_o, exp_wc); end
    endtask

    task automatic test_back_to_back();
        int           sent = 0;
        int           got = 0;
        logic [W-1:0] acc = '0;
        logic [W-1:0] w;
        exp_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            byte_v_i       = (sent < 32);
            byte_data_i    = 8'(sent * 7 + 3);
            stream_ready_i = cyc[0];
            #1;
            if (stream_v_o && stream_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got %h want no word", stream_data_o);
                end else begin
                    w = exp_q.pop_front();
                    if (stream_data_o !== w) begin errors++; $display("FAIL b2b_data_%0d: got %h want %h", got, stream_data_o, w); end
                end
                got++;
                exp_wc++;
            end
            if (byte_v_i && byte_ready_o) begin
                acc[(sent % 4)*8 +: 8] = byte_data_i;
                sent++;
                if (sent % 4 == 0) exp_q.push_back(acc);
            end
            if (got == 8) break;
            step();
        end
        step();
        byte_v_i = 1'b0; stream_ready_i = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("FAIL b2b_words: got %0d want 8", got); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_left: got %0d want 0", exp_q.size()); end
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL b2b_count: got %0d want %0d", word_count_o, exp_wc); end
    endtask

`ifdef BP_STREAM_PACKER_FLUSH_EN
    task automatic test_flush();
        bit seen = 0;
        stream_ready_i = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB);
        byte_v_i = 1'b0;
        repeat (1000) step();
        checks++; if (stream_v_o !== 1'b0) begin errors++; $display("FAIL fl_early: got %b want 0", stream_v_o); end
        for (int i = 0; i < 200 && !seen; i++) begin
            if (stream_v_o) seen = 1; else step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL fl_timeout: got no word want 0000bbaa"); end
        checks++; if (stream_data_o !== 32'h0000BBAA) begin errors++; $display("FAIL fl_data: got %h want 0000bbaa", stream_data_o); end
        stream_ready_i = 1'b1;
        step();
        exp_wc++;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        byte_v_i = 1'b0;
        checks++; if (stream_data_o !== 32'h04030201) begin errors++; $display("FAIL fl_next: got %h want 04030201", stream_data_o); end
        step();
        exp_wc++;
        checks++; if (word_count_o !== exp_wc) begin errors++; $display("FAIL fl_count: got %0d want %0d", word_count_o, exp_wc); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_back_to_back();
`ifdef BP_STREAM_PACKER_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
